fpu_resp_buffer: RTL and testbench
==================================

FPU_RESP_BUFFER -- requirements
Module: fpu_resp_buffer

Interface
REQ-001 Parameter ID_WIDTH, default 9, tag width carried with each request/response.
REQ-002 Parameter DATA_WIDTH, default 32, result width.
REQ-003 Parameter FLAGS_OUT_WIDTH, default 5, status flag width.
REQ-004 Parameter DEPTH, default 4, response FIFO entries and credit count; legal range 1..16.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 apu_req_i  input  1  core-side request valid.
REQ-008 apu_gnt_o  output  1  core-side grant.
REQ-009 fpu_req_o  output  1  request valid toward FPU wrapper.
REQ-010 fpu_gnt_i  input  1  FPU wrapper ready.
REQ-011 fpu_rvalid_i  input  1  FPU result valid; FPU cannot be stalled.
REQ-012 fpu_rdata_i / fpu_rflags_i / fpu_rID_i  input  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  FPU result payload.
REQ-013 apu_rvalid_o  output  1  core-side response valid.
REQ-014 apu_rready_i  input  1  core-side response ready.
REQ-015 apu_rdata_o / apu_rflags_o / apu_rID_o  output  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  buffered response payload.
REQ-016 overflow_o  output  1  sticky FIFO overflow indication.
REQ-017 Operands, opcode and flags SHALL bypass this block; only handshakes and responses pass through it.

Function
REQ-018 Credit counter SHALL be clog2(DEPTH+1) bits, reset to DEPTH.
REQ-019 fpu_req_o SHALL equal apu_req_i AND (credits != 0); apu_gnt_o SHALL equal fpu_gnt_i AND (credits != 0), combinationally.
REQ-020 Issue event = fpu_req_o AND fpu_gnt_i; pop event = apu_rvalid_o AND apu_rready_i.
REQ-021 Credits SHALL decrement by 1 on issue only, increment by 1 on pop only, and hold on both or neither.
REQ-022 Credits SHALL never exceed DEPTH nor go below 0; in-flight plus buffered responses never exceed DEPTH.
REQ-023 FIFO SHALL push {rdata, rflags, rID} on fpu_rvalid_i when not full, or when full with a same-cycle pop.
REQ-024 Pushed entry SHALL appear on apu_r*_o the cycle after push (1-cycle latency, no fall-through).
REQ-025 apu_rvalid_o SHALL be high iff FIFO occupancy != 0; payload outputs SHALL reflect the head entry and stay stable while apu_rvalid_o is high and apu_rready_i is low.
REQ-026 Read/write pointers SHALL wrap from DEPTH-1 to 0; occupancy counter distinguishes full from empty.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged and keep order.
REQ-028 Responses SHALL be delivered in FPU completion order; no reordering by ID.
REQ-029 fpu_rvalid_i while full with no pop SHALL drop the result and leave FIFO contents unchanged.

Reset
REQ-030 Reset SHALL asynchronously clear pointers and occupancy, set credits to DEPTH, clear overflow_o.
REQ-031 During and after reset apu_rvalid_o=0, apu_r*_o payload=0; fpu_req_o/apu_gnt_o follow REQ-019 with credits=DEPTH.
REQ-032 Reset mid-operation SHALL discard buffered and in-flight responses; results arriving after reset release are accepted as new entries.

Configuration
REQ-033 Macro FPU_RESP_OVF_CHECK_EN defined: overflow_o SHALL set on a dropped push (REQ-029) and hold until reset; simulation assertion fires on the same cycle.
REQ-034 Macro FPU_RESP_OVF_CHECK_EN undefined: overflow_o SHALL be tied 0, no detection logic or assertion present; drop behaviour unchanged.

Verification
REQ-035 Reset, apu_req_i=1, fpu_gnt_i=1, apu_rready_i=1, FPU result 1 cycle after each issue -> apu_gnt_o=1 every cycle, responses emerge 1 cycle after fpu_rvalid_i, credits return to 4.
REQ-036 DEPTH=4, apu_rready_i=0, 6 requests offered -> exactly 4 granted, apu_gnt_o=0 thereafter, 4 responses buffered in order, credits=0.
REQ-037 From REQ-036 state, raise apu_rready_i for 1 cycle -> first response (ID 0) popped, credits=1, next request granted same cycle as apu_req_i.
REQ-038 Push and pop same cycle at occupancy 2 -> occupancy stays 2, pointer wrap after 0x3 to 0x0 preserves order of IDs 3,4,5.
REQ-039 Force fpu_rvalid_i while full, apu_rready_i=0, data 0xDEADBEEF -> entry dropped, head unchanged, overflow_o=1 with FPU_RESP_OVF_CHECK_EN, 0 without.
REQ-040 Assert rst_n low with 3 buffered entries -> apu_rvalid_o=0 immediately, credits=4 and overflow_o=0 after release.

Source files
------------

// File: rtl/fpu_resp_buffer_if.sv
// FPU response buffer bus bundle: core-side (apu_*) and FPU-side (fpu_*)
// handshakes plus the response payload. Signal suffixes are from the
// buffer's point of view; the buffer uses the slave modport.
interface fpu_resp_buffer_if #(
   parameter int ID_WIDTH        = 9,
   parameter int DATA_WIDTH      = 32,
   parameter int FLAGS_OUT_WIDTH = 5
);
   logic                       apu_req_i;
   logic                       apu_gnt_o;
   logic                       fpu_req_o;
   logic                       fpu_gnt_i;
   logic                       fpu_rvalid_i;
   logic [DATA_WIDTH-1:0]      fpu_rdata_i;
   logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i;
   logic [ID_WIDTH-1:0]        fpu_rID_i;
   logic                       apu_rvalid_o;
   logic                       apu_rready_i;
   logic [DATA_WIDTH-1:0]      apu_rdata_o;
   logic [FLAGS_OUT_WIDTH-1:0] apu_rflags_o;
   logic [ID_WIDTH-1:0]        apu_rID_o;
   logic                       overflow_o;

   modport slave (
      input  apu_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
             fpu_rID_i, apu_rready_i,
      output apu_gnt_o, fpu_req_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o,
             apu_rID_o, overflow_o
   );

   modport master (
      output apu_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
             fpu_rID_i, apu_rready_i,
      input  apu_gnt_o, fpu_req_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o,
             apu_rID_o, overflow_o
   );
endinterface

// File: rtl/fpu_resp_buffer.sv
// FPU response buffer. Requests are throttled by a credit counter so that
// in-flight plus buffered results never exceed DEPTH (1..16); results from
// the (unstallable) FPU land in an in-order FIFO read by the core.
// Optional macro FPU_RESP_OVF_CHECK_EN: sticky overflow_o plus a simulation
// assertion on a dropped result. Without it overflow_o is tied low.
module fpu_resp_buffer #(
   parameter int ID_WIDTH        = 9,
   parameter int DATA_WIDTH      = 32,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int DEPTH           = 4
) (
   input logic             clk,
   input logic             rst_n,
   fpu_resp_buffer_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

   logic [CW-1:0] credit_q, credit_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [EW-1:0] mem_q [DEPTH];

   logic          credit_ok;
   logic          issue;
   logic          pop;
   logic          full;
   logic          push;
   logic [EW-1:0] head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign credit_ok     = (credit_q != '0);
   assign bus.fpu_req_o = bus.apu_req_i & credit_ok;
   assign bus.apu_gnt_o = bus.fpu_gnt_i & credit_ok;

   assign issue = bus.fpu_req_o & bus.fpu_gnt_i;
   assign pop   = bus.apu_rvalid_o & bus.apu_rready_i;
   assign full  = (occ_q == CW'(DEPTH));
   // A full FIFO can still take a result when the head leaves the same cycle.
   assign push  = bus.fpu_rvalid_i & (~full | pop);

   assign head             = mem_q[rptr_q];
   assign bus.apu_rvalid_o = (occ_q != '0);
   // Payload is forced to zero while empty so reset shows a clean bus.
   assign {bus.apu_rdata_o, bus.apu_rflags_o, bus.apu_rID_o} =
      bus.apu_rvalid_o ? head : '0;

   // Next-state for credits, occupancy and pointers.
   always_comb begin
      credit_d = credit_q;
      occ_d    = occ_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;

      if (issue && !pop) begin
         credit_d = credit_q - CW'(1);
      end else if (pop && !issue && credit_q != CW'(DEPTH)) begin
         credit_d = credit_q + CW'(1);
      end

      if (push && !pop) begin
         occ_d = occ_q + CW'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - CW'(1);
      end

      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
   end

   // Control state registers with async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= CW'(DEPTH);
         occ_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
      end else begin
         credit_q <= credit_d;
         occ_q    <= occ_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
      end
   end

   // Response storage; contents are only visible through the valid-gated head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {bus.fpu_rdata_i, bus.fpu_rflags_i, bus.fpu_rID_i};
      end
   end

`ifdef FPU_RESP_OVF_CHECK_EN
   logic drop;
   logic ovf_q;

   assign drop           = bus.fpu_rvalid_i & full & ~pop;
   assign bus.overflow_o = ovf_q;

   // Sticky record of any result lost to a full FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_no_drop : assert property (@(posedge clk) disable iff (!rst_n) !drop)
      else $error("fpu_resp_buffer: result dropped, FIFO full");
`endif
`else
   assign bus.overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_resp_buffer.sv
// Bench for fpu_resp_buffer: directed phases, a small FPU model with
// one-cycle latency, and a scoreboard queue checked by a negedge monitor.
module tb_fpu_resp_buffer;
   localparam int DEPTH = 4;
   localparam int IDW   = 9;
   localparam int DW    = 32;
   localparam int FW    = 5;
`ifdef FPU_RESP_OVF_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      logic [FW-1:0]  flags;
   } resp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fpu_resp_buffer_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW)) bus ();

   fpu_resp_buffer #(
      .ID_WIDTH(IDW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW), .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int       n_chk = 0;
   int       n_fail = 0;
   resp_t    exp_q[$];
   int       credits_m = DEPTH;
   logic     ovf_m = 1'b0;
   logic [IDW-1:0] id_cnt = '0;
   logic     pend_v = 1'b0;
   resp_t    pend_r;
   int       n_gnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic resp_t mk(input logic [IDW-1:0] id);
      resp_t r;
      r.id    = id;
      r.data  = 32'hC0DE_0000 | {23'd0, id};
      r.flags = id[4:0] ^ 5'h15;
      return r;
   endfunction

   task automatic drive_result();
      bus.fpu_rvalid_i = pend_v;
      bus.fpu_rdata_i  = pend_r.data;
      bus.fpu_rflags_i = pend_r.flags;
      bus.fpu_rID_i    = pend_r.id;
   endtask

   // Scoreboard monitor: valid must match model occupancy, head must match.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("apu_rvalid_o", bus.apu_rvalid_o, exp_q.size() != 0);
         chk("overflow_o", bus.overflow_o, ovf_m);
         if (bus.apu_rvalid_o && exp_q.size() != 0) begin
            chk("head_id", bus.apu_rID_o, exp_q[0].id);
            chk("head_data", bus.apu_rdata_o, exp_q[0].data);
            chk("head_flags", bus.apu_rflags_o, exp_q[0].flags);
            if (bus.apu_rready_i) void'(exp_q.pop_front());
         end
      end
   end

   // One clock: check handshakes at negedge, update model at posedge,
   // then drive the FPU result for anything issued this cycle.
   task automatic step();
      logic iss, pp;
      @(negedge clk);
      iss = bus.fpu_req_o && bus.fpu_gnt_i;
      pp  = bus.apu_rvalid_o && bus.apu_rready_i;
      chk("fpu_req_o", bus.fpu_req_o, bus.apu_req_i && (credits_m != 0));
      chk("apu_gnt_o", bus.apu_gnt_o, bus.fpu_gnt_i && (credits_m != 0));
      @(posedge clk);
      if (pend_v) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(pend_r);
         else ovf_m = OVF_EN;
      end
      if (iss && !pp) credits_m--;
      else if (pp && !iss) credits_m++;
      if (iss) n_gnt++;
      #1;
      if (iss) begin
         pend_v = 1'b1;
         pend_r = mk(id_cnt);
         id_cnt++;
      end else begin
         pend_v = 1'b0;
      end
      drive_result();
   endtask

   // Assert reset now, check reset outputs, release at posedge+1.
   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      credits_m = DEPTH;
      ovf_m     = 1'b0;
      pend_v    = 1'b0;
      drive_result();
      #1;
      chk("rst_apu_rvalid_o", bus.apu_rvalid_o, 1'b0);
      chk("rst_payload", {bus.apu_rdata_o, bus.apu_rflags_o, bus.apu_rID_o}, '0);
      chk("rst_fpu_req_o", bus.fpu_req_o, bus.apu_req_i);
      chk("rst_apu_gnt_o", bus.apu_gnt_o, bus.fpu_gnt_i);
      chk("rst_overflow_o", bus.overflow_o, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.apu_req_i    = 1'b1;
      bus.fpu_gnt_i    = 1'b1;
      bus.apu_rready_i = 1'b1;
      pend_r           = '0;
      drive_result();
      @(posedge clk);
      #1;
      do_reset();

      // Streaming: grant every cycle, responses one cycle after FPU result.
      repeat (8) step();
      bus.apu_req_i = 1'b0;
      repeat (3) step();

      // Core stalls: only DEPTH of six offered requests are granted.
      bus.apu_rready_i = 1'b0;
      bus.apu_req_i    = 1'b1;
      n_gnt            = 0;
      repeat (6) step();
      bus.apu_req_i = 1'b0;
      step();
      chk("grants_of_6", n_gnt, 4);

      // Spurious result into a full FIFO is dropped; head stays ID 0.
      pend_v = 1'b1;
      pend_r.id    = 9'h1FF;
      pend_r.data  = 32'hDEAD_BEEF;
      pend_r.flags = 5'h1F;
      drive_result();
      step();
      step();
      chk("overflow_after_drop", bus.overflow_o, OVF_EN);

      // One pop returns a credit; the next request is granted at once.
      bus.apu_rready_i = 1'b1;
      bus.apu_req_i    = 1'b1;
      step();
      bus.apu_rready_i = 1'b0;
      step();
      chk("regrant_after_pop", n_gnt, 5);
      bus.apu_req_i = 1'b0;
      repeat (2) step();

      // Concurrent push/pop with pointers wrapping repeatedly.
      bus.apu_rready_i = 1'b1;
      repeat (2) step();
      bus.apu_req_i = 1'b1;
      repeat (10) step();
      bus.apu_req_i = 1'b0;
      repeat (4) step();

      // Reset with three buffered entries, asserted mid-cycle.
      bus.apu_rready_i = 1'b0;
      bus.apu_req_i    = 1'b1;
      repeat (3) step();
      bus.apu_req_i = 1'b0;
      step();
      chk("three_buffered", bus.apu_rvalid_o, 1'b1);
      #2;
      do_reset();

      // Traffic after reset release is accepted as new entries.
      bus.apu_rready_i = 1'b1;
      bus.apu_req_i    = 1'b1;
      repeat (6) step();
      bus.apu_req_i = 1'b0;
      repeat (3) step();
      chk("final_rvalid", bus.apu_rvalid_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
